// File: rtl/pmul_seq_ctrl.sv
// Coefficient-schedule sequencer for the shift-register polynomial multiplier.
// Optional feature: define PMUL_SEQ_CONT_EN for back-to-back runs straight out of DONE.
module pmul_seq_ctrl #(
    parameter int N = 4,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] n_active,
    input  logic          stall,
    output logic          csr1_load,
    output logic          csr1_en,
    output logic          csr2_load,
    output logic          csr2_en,
    output logic          acc_clr,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] outer_idx,
    output logic [CW-1:0] inner_idx
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CW-1:0] N_MAX = CW'(N);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] n_lat_q, n_lat_d;
    logic [CW-1:0] outer_q, outer_d;
    logic [CW-1:0] inner_q, inner_d;
    logic          stalled_q, stalled_d;
    logic [CW-1:0] n_clamped;
    logic [CW-1:0] n_last;
    logic          outer_end;

    assign n_clamped = (n_active == '0 || n_active > N_MAX) ? N_MAX : n_active;
    assign n_last    = n_lat_q - ONE;
    assign outer_end = (state_q == S_ISSUE && n_lat_q == ONE) ||
                       (state_q == S_SHIFT && inner_q == n_last);

    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        n_lat_d   = n_lat_q;
        outer_d   = outer_q;
        inner_d   = inner_q;
        stalled_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    n_lat_d = n_clamped;
                end
            end
            S_LOAD: begin
                state_d = S_ISSUE;
                outer_d = '0;
                inner_d = '0;
            end
            S_ISSUE, S_SHIFT: begin
                // A sampled stall holds the step; the strobes for it were already issued.
                if (stall) begin
                    stalled_d = 1'b1;
                end else if (outer_end) begin
                    inner_d = '0;
                    if (outer_q == n_last) begin
                        state_d = S_DONE;
                        outer_d = '0;
                    end else begin
                        state_d = S_ISSUE;
                        outer_d = outer_q + ONE;
                    end
                end else begin
                    state_d = S_SHIFT;
                    inner_d = inner_q + ONE;
                end
            end
            S_DONE: begin
`ifdef PMUL_SEQ_CONT_EN
                if (start) begin
                    state_d = S_LOAD;
                    n_lat_d = n_clamped;
                end else begin
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            n_lat_q   <= N_MAX;
            outer_q   <= '0;
            inner_q   <= '0;
            stalled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_lat_q   <= n_lat_d;
            outer_q   <= outer_d;
            inner_q   <= inner_d;
            stalled_q <= stalled_d;
        end
    end

    // Strobes decode from registers only; a held step shows with its enables suppressed.
    assign csr1_load = (state_q == S_LOAD);
    assign acc_clr   = (state_q == S_LOAD);
    assign csr2_load = (state_q == S_ISSUE) && !stalled_q;
    assign csr1_en   = (state_q == S_ISSUE) && !stalled_q;
    assign csr2_en   = (state_q == S_ISSUE || state_q == S_SHIFT) && !stalled_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign outer_idx = outer_q;
    assign inner_idx = inner_q;

endmodule

// File: tb/tb_pmul_seq_ctrl.sv
// Directed bench for pmul_seq_ctrl (N=4): table of runs plus reset and continuous-start sequences.
module tb_pmul_seq_ctrl;

    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] n_active;
    logic          stall;
    logic          csr1_load, csr1_en, csr2_load, csr2_en, acc_clr, busy, done;
    logic [CW-1:0] outer_idx, inner_idx;
    logic [12:0]   outs;

    int total = 0;
    int bad   = 0;

    pmul_seq_ctrl #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .n_active  (n_active),
        .stall     (stall),
        .csr1_load (csr1_load),
        .csr1_en   (csr1_en),
        .csr2_load (csr2_load),
        .csr2_en   (csr2_en),
        .acc_clr   (acc_clr),
        .busy      (busy),
        .done      (done),
        .outer_idx (outer_idx),
        .inner_idx (inner_idx)
    );

    always #5 clk = ~clk;

    assign outs = {csr1_load, csr1_en, csr2_load, csr2_en, acc_clr, busy, done, outer_idx, inner_idx};

    typedef struct {
        logic [CW-1:0] n_in;
        int            n_eff;
        int            stall_len;
        bit            poke;
        int            exp_done;
        int            exp_c2load;
        int            exp_c2en;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One start-to-done run; the index/strobe order is checked against a simple step model.
    task automatic run_case(input vec_t v, input int id);
        int cnt, done_at, k;
        int c1l, ac, c2l, c2e, c1e;
        int seq_err, busy_err, frz_err, stall_rem;
        bit stall_active, stall_used;
        string tag;
        tag = $sformatf("case%0d", id);
        cnt = 0; done_at = -1; k = 0;
        c1l = 0; ac = 0; c2l = 0; c2e = 0; c1e = 0;
        seq_err = 0; busy_err = 0; frz_err = 0; stall_rem = 0;
        stall_active = 0; stall_used = 0;
        @(negedge clk);
        start    = 1'b1;
        n_active = v.n_in;
        while (done_at < 0 && cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) start = 1'b0;
            if (v.poke && cnt == 6) begin start = 1'b1; n_active = CW'(1); end
            if (v.poke && cnt == 7) begin start = 1'b0; n_active = v.n_in; end
            if (!busy) busy_err++;
            c1l += int'(csr1_load); ac += int'(acc_clr);
            c2l += int'(csr2_load); c2e += int'(csr2_en); c1e += int'(csr1_en);
            if (int'(outer_idx) >= v.n_eff || int'(inner_idx) >= v.n_eff) seq_err++;
            if (csr2_en) begin
                if (int'(outer_idx) != k / v.n_eff || int'(inner_idx) != k % v.n_eff) seq_err++;
                if (csr2_load !== (k % v.n_eff == 0)) seq_err++;
                if (csr1_en !== csr2_load) seq_err++;
                k++;
            end else if (csr2_load || csr1_en) begin
                seq_err++;
            end
            if (stall_active) begin
                if (outer_idx !== CW'(1) || inner_idx !== CW'(1) || csr1_en || csr2_en || csr2_load)
                    frz_err++;
                stall_rem--;
                if (stall_rem == 0) begin stall = 1'b0; stall_active = 0; end
            end else if (v.stall_len > 0 && !stall_used && csr2_en &&
                         outer_idx == CW'(1) && inner_idx == CW'(1)) begin
                stall = 1'b1; stall_active = 1; stall_used = 1; stall_rem = v.stall_len;
            end
            if (done) done_at = cnt;
        end
        stall = 1'b0;
        start = 1'b0;
        check({tag, " done_cycle"}, done_at, v.exp_done);
        check({tag, " csr1_load_cnt"}, c1l, 1);
        check({tag, " acc_clr_cnt"}, ac, 1);
        check({tag, " csr2_load_cnt"}, c2l, v.exp_c2load);
        check({tag, " csr1_en_cnt"}, c1e, v.exp_c2load);
        check({tag, " csr2_en_cnt"}, c2e, v.exp_c2en);
        check({tag, " sequence_errs"}, seq_err, 0);
        check({tag, " busy_errs"}, busy_err, 0);
        if (v.stall_len > 0) begin
            check({tag, " stall_applied"}, 32'(stall_used), 1);
            check({tag, " stall_frozen_errs"}, frz_err, 0);
        end
        @(negedge clk);
        check({tag, " idle_after_done"}, {busy, done}, 0);
    endtask

    initial begin
        int cnt, first, second, done_seen, busy_after;
        vecs[0] = '{n_in: 3'd4, n_eff: 4, stall_len: 0, poke: 0, exp_done: 18, exp_c2load: 4, exp_c2en: 16};
        vecs[1] = '{n_in: 3'd0, n_eff: 4, stall_len: 0, poke: 0, exp_done: 18, exp_c2load: 4, exp_c2en: 16};
        vecs[2] = '{n_in: 3'd7, n_eff: 4, stall_len: 0, poke: 0, exp_done: 18, exp_c2load: 4, exp_c2en: 16};
        vecs[3] = '{n_in: 3'd1, n_eff: 1, stall_len: 0, poke: 0, exp_done: 3,  exp_c2load: 1, exp_c2en: 1};
        vecs[4] = '{n_in: 3'd2, n_eff: 2, stall_len: 0, poke: 0, exp_done: 6,  exp_c2load: 2, exp_c2en: 4};
        vecs[5] = '{n_in: 3'd3, n_eff: 3, stall_len: 0, poke: 0, exp_done: 11, exp_c2load: 3, exp_c2en: 9};
        vecs[6] = '{n_in: 3'd3, n_eff: 3, stall_len: 5, poke: 0, exp_done: 16, exp_c2load: 3, exp_c2en: 9};
        vecs[7] = '{n_in: 3'd4, n_eff: 4, stall_len: 0, poke: 1, exp_done: 18, exp_c2load: 4, exp_c2en: 16};

        reset = 1'b1; start = 1'b0; stall = 1'b0; n_active = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(outs), 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_outputs", 32'(outs), 0);

        for (int i = 0; i < 8; i++) run_case(vecs[i], i);

        // Reset in the middle of a SHIFT step.
        @(negedge clk);
        start = 1'b1; n_active = 3'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_in_shift", {csr2_en, csr2_load}, 2'b10);
        reset = 1'b1;
        @(negedge clk);
        check("midrun_reset_outputs", 32'(outs), 0);
        reset = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            done_seen += int'(done);
        end
        check("no_done_after_reset", done_seen, 0);
        run_case(vecs[0], 8);

        // Start held high across runs.
        @(negedge clk);
        start = 1'b1; n_active = 3'd4;
        cnt = 0; first = -1; second = -1; busy_after = -1;
        while (second < 0 && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (first > 0 && cnt == first + 1) busy_after = int'(busy);
            if (done) begin
                if (first < 0) first = cnt;
                else second = cnt;
            end
        end
        start = 1'b0;
        check("cont_first_done", first, 18);
`ifdef PMUL_SEQ_CONT_EN
        check("cont_done_period", second - first, 18);
        check("cont_busy_after_done", busy_after, 1);
`else
        check("cont_done_period", second - first, 19);
        check("cont_busy_after_done", busy_after, 0);
`endif
        cnt = 0;
        while (busy && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("cont_returns_idle", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
